// File: rtl/mdu_pkg.sv
// ============================================================================
// Module   : mdu_pkg
// Purpose  : Shared op codes, sequencer states and add/sub selects for the MDU.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package mdu_pkg;

    localparam logic [1:0] MDU_MULT  = 2'b00;
    localparam logic [1:0] MDU_MULTU = 2'b01;
    localparam logic [1:0] MDU_DIV   = 2'b10;
    localparam logic [1:0] MDU_DIVU  = 2'b11;

    // Select encoding matches the ALU so both units decode the same field.
    localparam logic [5:0] ADDSUB_ADD = 6'b000000;
    localparam logic [5:0] ADDSUB_SUB = 6'b000001;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_PREP = 3'd1,
        ST_RUN  = 3'd2,
        ST_FIX  = 3'd3,
        ST_DONE = 3'd4
    } mdu_state_t;

endpackage

`default_nettype wire

// File: rtl/mdu_seq_if.sv
// ============================================================================
// Module   : mdu_seq_if
// Purpose  : Request/result and MTHI/MTLO bundle between pipeline and MDU.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface mdu_seq_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             hi_we;
    logic             lo_we;
    logic [WIDTH-1:0] wdata;
    logic             busy;
    logic             done;
    logic             div0;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, op, a, b, hi_we, lo_we, wdata,
        input  busy, done, div0, hi, lo
    );

    modport slave (
        input  start, op, a, b, hi_we, lo_we, wdata,
        output busy, done, div0, hi, lo
    );
endinterface

`default_nettype wire

// File: rtl/mdu_addsub.sv
// ============================================================================
// Module   : mdu_addsub
// Purpose  : Combinational N-bit add/subtract; o_cout is carry (add) or
//            not-borrow (sub).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mdu_addsub
    import mdu_pkg::*;
#(
    parameter int N = 33
) (
    input  wire logic [N-1:0] i_x,
    input  wire logic [N-1:0] i_y,
    input  wire logic [5:0]   i_sel,
    output logic      [N-1:0] o_sum,
    output logic              o_cout
);

    logic         w_sub;
    logic [N-1:0] w_y_eff;
    logic [N:0]   w_full;

    assign w_sub   = (i_sel == ADDSUB_SUB);
    assign w_y_eff = w_sub ? ~i_y : i_y;
    assign w_full  = {1'b0, i_x} + {1'b0, w_y_eff} + {{N{1'b0}}, w_sub};
    assign o_sum   = w_full[N-1:0];
    assign o_cout  = w_full[N];

endmodule

`default_nettype wire

// File: rtl/mdu_seq.sv
// ============================================================================
// Module   : mdu_seq
// Purpose  : Iterative MULT/MULTU/DIV/DIVU sequencer owning the HI/LO pair.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mdu_seq
    import mdu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  wire logic  clk,
    input  wire logic  rst_n,
    mdu_seq_if.slave   bus
);

    localparam int CW = $clog2(WIDTH);

    mdu_state_t       r_state, w_state_nxt;
    logic [1:0]       r_op;
    logic [WIDTH-1:0] r_a, r_b, r_acc, r_q, r_mcand, r_hi, r_lo;
    logic [CW-1:0]    r_cnt;
    logic             r_neg_res, r_neg_rem, r_div0;

    logic             w_busy, w_done, w_accept, w_mt_ok;
    logic             w_is_div, w_signed, w_b_zero, w_cout;
    logic [WIDTH-1:0] w_a_mag, w_b_mag, w_quo_fix, w_rem_fix;
    logic [WIDTH:0]   w_rem_sh, w_x, w_y, w_sum, w_mul_ext;
    logic [5:0]       w_sel;
    logic [2*WIDTH-1:0] w_prod, w_prod_fix;

    always_ff @(posedge clk) begin
        if (!rst_n) r_state <= ST_IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_busy      = 1'b0;
        w_done      = 1'b0;
        w_accept    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (bus.start) begin
                    w_accept    = 1'b1;
                    w_state_nxt = ST_PREP;
                end
            end
            ST_PREP: begin
                w_busy      = 1'b1;
                w_state_nxt = ST_RUN;
            end
            ST_RUN: begin
                w_busy = 1'b1;
                if (r_cnt == '0) w_state_nxt = ST_FIX;
            end
            ST_FIX: begin
                w_busy      = 1'b1;
                w_state_nxt = ST_DONE;
            end
            ST_DONE: begin
                w_done = 1'b1;
                if (bus.start) begin
                    w_accept    = 1'b1;
                    w_state_nxt = ST_PREP;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Start has priority over MTHI/MTLO in the same cycle.
    assign w_mt_ok  = ((r_state == ST_IDLE) || (r_state == ST_DONE)) && !bus.start;
    assign w_is_div = r_op[1];
    assign w_signed = ~r_op[0];
    assign w_b_zero = (r_b == '0);
    assign w_a_mag  = (w_signed && r_a[WIDTH-1]) ? -r_a : r_a;
    assign w_b_mag  = (w_signed && r_b[WIDTH-1]) ? -r_b : r_b;

    // Divide trial-subtracts from the shifted remainder; multiply accumulates.
    assign w_rem_sh = {r_acc, r_q[WIDTH-1]};
    assign w_x      = w_is_div ? w_rem_sh : {1'b0, r_acc};
    assign w_y      = {1'b0, r_mcand};
    assign w_sel    = w_is_div ? ADDSUB_SUB : ADDSUB_ADD;

    mdu_addsub #(.N(WIDTH + 1)) u_addsub (
        .i_x    (w_x),
        .i_y    (w_y),
        .i_sel  (w_sel),
        .o_sum  (w_sum),
        .o_cout (w_cout)
    );

    assign w_mul_ext  = r_q[0] ? w_sum : {1'b0, r_acc};
    assign w_prod     = {r_acc, r_q};
    assign w_prod_fix = r_neg_res ? -w_prod : w_prod;
    assign w_quo_fix  = r_neg_res ? -r_q : r_q;
    assign w_rem_fix  = r_neg_rem ? -r_acc : r_acc;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_op      <= '0;
            r_a       <= '0;
            r_b       <= '0;
            r_acc     <= '0;
            r_q       <= '0;
            r_mcand   <= '0;
            r_cnt     <= '0;
            r_neg_res <= 1'b0;
            r_neg_rem <= 1'b0;
            r_div0    <= 1'b0;
            r_hi      <= '0;
            r_lo      <= '0;
        end else begin
            if (w_accept) begin
                r_a  <= bus.a;
                r_b  <= bus.b;
                r_op <= bus.op;
            end else if (w_mt_ok) begin
                if (bus.hi_we) r_hi <= bus.wdata;
                if (bus.lo_we) r_lo <= bus.wdata;
            end
            case (r_state)
                ST_PREP: begin
                    r_acc     <= '0;
                    r_cnt     <= CW'(WIDTH - 1);
                    r_neg_res <= w_signed & (r_a[WIDTH-1] ^ r_b[WIDTH-1]);
                    r_neg_rem <= w_signed & r_a[WIDTH-1];
                    r_q       <= w_is_div ? w_a_mag : w_b_mag;
                    r_mcand   <= w_is_div ? w_b_mag : w_a_mag;
                end
                ST_RUN: begin
                    if (r_cnt != '0) r_cnt <= r_cnt - 1'b1;
                    if (w_is_div) begin
                        r_acc <= w_cout ? w_sum[WIDTH-1:0] : w_rem_sh[WIDTH-1:0];
                        r_q   <= {r_q[WIDTH-2:0], w_cout};
                    end else begin
                        r_acc <= w_mul_ext[WIDTH:1];
                        r_q   <= {w_mul_ext[0], r_q[WIDTH-1:1]};
                    end
                end
                ST_FIX: begin
                    r_div0 <= w_is_div & w_b_zero;
                    if (!w_is_div) begin
                        {r_hi, r_lo} <= w_prod_fix;
                    end else if (w_b_zero) begin
                        r_hi <= r_a;
                        r_lo <= '1;
                    end else begin
                        r_hi <= w_rem_fix;
                        r_lo <= w_quo_fix;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.busy = w_busy;
    assign bus.done = w_done;
    assign bus.div0 = w_done & r_div0;
    assign bus.hi   = r_hi;
    assign bus.lo   = r_lo;

endmodule

`default_nettype wire

// File: tb/tb_mdu_seq.sv
// ============================================================================
// Module   : tb_mdu_seq
// Purpose  : Directed self-checking bench for the iterative mult/div unit.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mdu_seq;
    import mdu_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    int   n_total = 0;
    int   n_bad   = 0;

    mdu_seq_if #(.WIDTH(32)) bus ();

    mdu_seq #(.WIDTH(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic launch(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        bus.op    = op;
        bus.a     = a;
        bus.b     = b;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
    endtask

    // Called in cycle 1 after launch; returns in the done cycle (cyc=-1 on timeout).
    task automatic wait_done(input int inject, output int cyc, output int busy_bad,
                             output logic [31:0] h, output logic [31:0] l, output logic d0);
        cyc = -1; busy_bad = 0; h = '0; l = '0; d0 = 1'b0;
        for (int c = 1; c <= 40; c++) begin
            if (bus.done) begin
                cyc = c; h = bus.hi; l = bus.lo; d0 = bus.div0;
                return;
            end
            if (bus.busy !== 1'b1) busy_bad++;
            if (c == inject) begin
                bus.start = 1'b1; bus.op = MDU_DIV; bus.a = 32'd1; bus.b = 32'd1;
                bus.hi_we = 1'b1; bus.wdata = 32'hDEADBEEF;
                tick();
                bus.start = 1'b0; bus.hi_we = 1'b0;
            end else begin
                tick();
            end
        end
    endtask

    task automatic run_check(input string tag, input logic [1:0] op, input logic [31:0] a,
                             input logic [31:0] b, input logic [31:0] eh,
                             input logic [31:0] el, input logic ed0);
        int cyc, bb;
        logic [31:0] h, l;
        logic d0;
        launch(op, a, b);
        wait_done(0, cyc, bb, h, l, d0);
        check_eq({tag, "_cyc"}, 64'(cyc), 64'd35);
        check_eq({tag, "_hilo"}, {h, l}, {eh, el});
        check_eq({tag, "_div0"}, 64'(d0), 64'(ed0));
    endtask

    initial begin
        int cyc, bb;
        logic [31:0] h, l;
        logic d0;

        rst_n = 1'b0;
        bus.start = 1'b0; bus.op = 2'b00; bus.a = '0; bus.b = '0;
        bus.hi_we = 1'b0; bus.lo_we = 1'b0; bus.wdata = '0;
        tick(); tick();
        check_eq("rst_busy", 64'(bus.busy), 64'd0);
        check_eq("rst_done", 64'(bus.done), 64'd0);
        check_eq("rst_div0", 64'(bus.div0), 64'd0);
        check_eq("rst_hilo", {bus.hi, bus.lo}, 64'd0);
        rst_n = 1'b1;
        tick();

        launch(MDU_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF);
        wait_done(0, cyc, bb, h, l, d0);
        check_eq("multu_cyc", 64'(cyc), 64'd35);
        check_eq("multu_busy", 64'(bb), 64'd0);
        check_eq("multu_hilo", {h, l}, 64'hFFFFFFFE_00000001);
        tick();
        check_eq("idle_after_done", {62'd0, bus.busy, bus.done}, 64'd0);

        run_check("mult_neg",  MDU_MULT,  32'hFFFFFFFD, 32'd7,        32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0);
        run_check("mult_min",  MDU_MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h0,        1'b0);
        run_check("div_neg",   MDU_DIV,   32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0);
        run_check("divu",      MDU_DIVU,  32'd100,      32'd7,        32'd2,        32'd14,       1'b0);
        run_check("div_ovf",   MDU_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h0,        32'h80000000, 1'b0);
        run_check("divu_zero", MDU_DIVU,  32'h12345678, 32'h0,        32'h12345678, 32'hFFFFFFFF, 1'b1);
        run_check("after_z",   MDU_MULTU, 32'd3,        32'd5,        32'h0,        32'd15,       1'b0);
        run_check("div_zero",  MDU_DIV,   32'hFFFFFFFB, 32'h0,        32'hFFFFFFFB, 32'hFFFFFFFF, 1'b1);

        // Start and MTHI while busy are dropped; HI keeps the previous result.
        launch(MDU_DIVU, 32'd100, 32'd7);
        wait_done(5, cyc, bb, h, l, d0);
        check_eq("busy_ign_cyc", 64'(cyc), 64'd35);
        check_eq("busy_ign_hilo", {h, l}, {32'd2, 32'd14});
        check_eq("busy_ign_busy", 64'(bb), 64'd0);

        // Start in the DONE cycle, together with a MTHI that must lose.
        bus.hi_we = 1'b1; bus.wdata = 32'hDEADBEEF;
        launch(MDU_MULTU, 32'd6, 32'd7);
        bus.hi_we = 1'b0;
        check_eq("chain_busy", 64'(bus.busy), 64'd1);
        check_eq("chain_hi_hold", 64'(bus.hi), 64'd2);
        wait_done(0, cyc, bb, h, l, d0);
        check_eq("chain_cyc", 64'(cyc), 64'd35);
        check_eq("chain_hilo", {h, l}, 64'd42);

        // Reset during RUN iteration 10 (cycle 12) aborts without a done pulse.
        tick();
        launch(MDU_MULTU, 32'd9, 32'd9);
        for (int i = 0; i < 11; i++) tick();
        check_eq("pre_abort_busy", 64'(bus.busy), 64'd1);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check_eq("abort_busy", 64'(bus.busy), 64'd0);
        check_eq("abort_hilo", {bus.hi, bus.lo}, 64'd0);
        bb = 0;
        for (int i = 0; i < 30; i++) begin
            if (bus.done || bus.busy) bb++;
            tick();
        end
        check_eq("abort_quiet", 64'(bb), 64'd0);

        bus.lo_we = 1'b1; bus.wdata = 32'h55;
        tick();
        bus.lo_we = 1'b0;
        check_eq("mtlo", {bus.hi, bus.lo}, 64'h55);
        bus.hi_we = 1'b1; bus.lo_we = 1'b1; bus.wdata = 32'hA5A5A5A5;
        tick();
        bus.hi_we = 1'b0; bus.lo_we = 1'b0; bus.wdata = 32'h0;
        tick(); tick();
        check_eq("mthi_mtlo_hold", {bus.hi, bus.lo}, 64'hA5A5A5A5_A5A5A5A5);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/mdu_seq.md
Name: mdu_seq

Overview:
- Iterative multiply/divide sequencer for the MIPS core; implements MULT, MULTU, DIV and DIVU and owns the HI/LO registers.
- Runs alongside the single-cycle arithmetic/logic unit in the EX stage.
- Performs one shift-add or shift-subtract step per cycle on a local (WIDTH+1)-bit add/sub path, then applies sign correction.
- Asserts busy so the pipeline control stalls MFHI/MFLO and new mult/div until the result is committed.

Parameters:
WIDTH, 32, operand width; HI and LO are each WIDTH bits.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst_n  in  1  synchronous reset, active-low.
- start  in  1  launch request; sampled only when the block is in IDLE or DONE.
- op  in  2  operation: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- a  in  WIDTH  multiplicand / dividend, captured when start is accepted.
- b  in  WIDTH  multiplier / divisor, captured when start is accepted.
- hi_we  in  1  MTHI write enable.
- lo_we  in  1  MTLO write enable.
- wdata  in  WIDTH  MTHI/MTLO write data.
- busy  out  1  high while an operation is in flight.
- done  out  1  one-cycle pulse; hi/lo hold the new result.
- div0  out  1  high together with done when a divide had b==0.
- hi  out  WIDTH  HI register.
- lo  out  WIDTH  LO register.

Behaviour:
- Reset: synchronous. When rst_n is sampled low, state goes to IDLE and hi=0, lo=0, busy=0, done=0, div0=0. This applies in every state, including mid-operation; the aborted result is discarded.
- States: IDLE, PREP, RUN, FIX, DONE.
- IDLE: if start, capture a, b and op, then go to PREP. Otherwise stay.
- PREP: busy=1. For signed ops, form magnitudes |a| and |b| and record neg_res = a[MSB]^b[MSB] and neg_rem = a[MSB]. For unsigned ops, neg_res=0 and neg_rem=0. Clear the accumulator, load the iteration counter with WIDTH-1, go to RUN.
- RUN: busy=1, exactly WIDTH cycles.
  - Multiply step: if the multiplier LSB is 1, add the multiplicand into the upper half using the (WIDTH+1)-bit add, keeping the carry. Then shift the {acc, multiplier} pair right by 1.
  - Divide step (restoring): shift {rem, quotient} left by 1. Trial-subtract the divisor. If the result is non-negative, keep it and set the quotient LSB to 1.
  - When the counter reaches 0, go to FIX; otherwise decrement.
- FIX: busy=1.
  - Multiply: if neg_res, negate the 2*WIDTH-bit product. Write {hi, lo} = product.
  - Divide: if neg_res, negate the quotient; if neg_rem, negate the remainder. Write hi = remainder, lo = quotient.
  - Go to DONE.
- DONE: busy=0, done=1 for this cycle only. DONE accepts start exactly like IDLE; otherwise go to IDLE.
- Latency: start accepted at edge 0 gives busy high for cycles 1..WIDTH+2 and done high in cycle WIDTH+3 (cycle 35 for WIDTH=32).
- Signed division truncates toward zero; the remainder takes the sign of the dividend.
- DIV of 0x80000000 by 0xFFFFFFFF gives lo=0x80000000, hi=0, with no flag.
- Divide by zero (either signed or unsigned): hi=a (the original operand), lo=all ones, and div0=1 in the DONE cycle.
- start while busy is ignored; no queueing.
- hi_we/lo_we are honoured only in IDLE/DONE and ignored while busy. If start and hi_we/lo_we are accepted in the same cycle, start wins and the write is dropped. If hi_we and lo_we are both high, both registers take wdata.
- hi/lo change only in FIX, on MTHI/MTLO, or at reset. They hold their values at all other times.

Decomposition:
- Package mdu_pkg holds:
  - op codes MDU_MULT=2'b00, MDU_MULTU=2'b01, MDU_DIV=2'b10, MDU_DIVU=2'b11;
  - the state enum (IDLE, PREP, RUN, FIX, DONE);
  - the add/sub select constants, shared with the ALU: add=6'b000000, sub=6'b000001.
- One sub-module, mdu_addsub: combinational (WIDTH+1)-bit add/subtract with carry/borrow out, used by both the multiply and divide steps.

Test Plan:
- MULTU a=0xFFFFFFFF, b=0xFFFFFFFF → done in cycle 35, hi=0xFFFFFFFE, lo=0x00000001, busy high for cycles 1..34.
- MULT a=0xFFFFFFFD (-3), b=7 → hi=0xFFFFFFFF, lo=0xFFFFFFEB. MULT 0x80000000×0x80000000 → hi=0x40000000, lo=0.
- DIV a=-7, b=2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU a=100, b=7 → lo=14, hi=2. DIV 0x80000000/0xFFFFFFFF → lo=0x80000000, hi=0.
- DIVU a=0x12345678, b=0 → hi=0x12345678, lo=0xFFFFFFFF, div0=1 with done. Next operation leaves div0=0.
- While busy: assert start (op=DIV) and hi_we=1, wdata=0xDEADBEEF → both ignored, original result delivered. In the DONE cycle assert start for a new op → accepted, no IDLE gap, done 35 cycles later.
- rst_n low at RUN iteration 10 → next cycle busy=0, hi=lo=0, no done pulse. Subsequent MTLO 0x55 in IDLE → lo=0x55 next cycle.
